// File: rtl/odesa_layer_n.sv
// ODESA feature layer: N neurons over M decaying spike traces, 3-stage pipeline with
// thresholded winner-take-all. Define THRESH_ADAPT_EN for adaptive per-neuron thresholds.
module odesa_layer_n #(
  parameter int unsigned P_WIDTH   = 9,
  parameter int unsigned P_N_IN    = 2,
  parameter int unsigned P_N_NEUR  = 4,
  parameter int unsigned P_DECAY   = 1,
  parameter int unsigned P_ETA     = 4,
  parameter int unsigned P_THR_DEC = 8,
  localparam int unsigned LVW = 2 * P_WIDTH + $clog2(P_N_IN),
  localparam int unsigned WW  = $clog2(P_N_NEUR)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [P_N_IN-1:0]                i_event,
  input  logic                             i_tick,
  input  logic [P_N_NEUR*P_N_IN*P_WIDTH-1:0] i_weight,
  input  logic [P_N_NEUR*LVW-1:0]          i_threshold,
  output logic [P_N_IN*P_WIDTH-1:0]        o_tr,
  output logic [P_N_NEUR*LVW-1:0]          o_lv,
  output logic [P_N_NEUR*LVW-1:0]          o_threshold,
  output logic [P_N_NEUR-1:0]              o_spike,
  output logic                             o_spike_valid,
  output logic [WW-1:0]                    o_winner
);

  localparam logic [P_WIDTH-1:0] Decay = P_WIDTH'(P_DECAY);

  logic [P_WIDTH-1:0]  tr_q [P_N_IN];
  logic [LVW-1:0]      lv_q [P_N_NEUR];
  logic [LVW-1:0]      lv_d [P_N_NEUR];
  logic [LVW-1:0]      thr  [P_N_NEUR];
  logic                v1_q, v2_q;
  logic [P_N_NEUR-1:0] spike_q;
  logic                spike_valid_q;
  logic [WW-1:0]       winner_q;

  logic                found;
  logic [WW-1:0]       best_idx;
  logic [LVW-1:0]      best_lv;

  // S0: events reload to full scale and take priority over decay
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 0; j < P_N_IN; j++) tr_q[j] <= '0;
    end else begin
      for (int j = 0; j < P_N_IN; j++) begin
        if (i_event[j]) begin
          tr_q[j] <= '1;
        end else if (i_tick) begin
          tr_q[j] <= (tr_q[j] > Decay) ? tr_q[j] - Decay : '0;
        end
      end
    end
  end

  // S1: weighted sum of traces per neuron
  always_comb begin
    for (int k = 0; k < P_N_NEUR; k++) begin
      lv_d[k] = '0;
      for (int j = 0; j < P_N_IN; j++) begin
        lv_d[k] = lv_d[k] + LVW'(tr_q[j]) * LVW'(i_weight[(k*P_N_IN+j)*P_WIDTH +: P_WIDTH]);
      end
    end
  end

  // S2: strict '>' keeps the lowest index on ties
  always_comb begin
    found    = 1'b0;
    best_idx = '0;
    best_lv  = '0;
    for (int k = 0; k < P_N_NEUR; k++) begin
      if (lv_q[k] >= thr[k] && (!found || lv_q[k] > best_lv)) begin
        found    = 1'b1;
        best_idx = WW'(k);
        best_lv  = lv_q[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
      winner_q      <= '0;
      for (int k = 0; k < P_N_NEUR; k++) lv_q[k] <= '0;
    end else begin
      v1_q          <= |i_event;
      v2_q          <= v1_q;
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
      if (v1_q) begin
        for (int k = 0; k < P_N_NEUR; k++) lv_q[k] <= lv_d[k];
      end
      if (v2_q && found) begin
        spike_q       <= P_N_NEUR'(1) << best_idx;
        spike_valid_q <= 1'b1;
        winner_q      <= best_idx;
      end
    end
  end

`ifdef THRESH_ADAPT_EN
  localparam logic [LVW-1:0] ThrDec = LVW'(P_THR_DEC);

  logic [LVW-1:0] thr_q [P_N_NEUR];

  // Winner drifts toward its potential; an unclaimed event lowers every threshold
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < P_N_NEUR; k++) thr_q[k] <= i_threshold[k*LVW +: LVW];
    end else if (v2_q) begin
      for (int k = 0; k < P_N_NEUR; k++) begin
        if (found) begin
          if (WW'(k) == best_idx) begin
            thr_q[k] <= thr_q[k] + ((lv_q[k] - thr_q[k]) >> P_ETA);
          end
        end else begin
          thr_q[k] <= (thr_q[k] > ThrDec) ? thr_q[k] - ThrDec : '0;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < P_N_NEUR; k++) thr[k] = thr_q[k];
  end
`else
  always_comb begin
    for (int k = 0; k < P_N_NEUR; k++) thr[k] = i_threshold[k*LVW +: LVW];
  end
`endif

  always_comb begin
    for (int j = 0; j < P_N_IN; j++) o_tr[j*P_WIDTH +: P_WIDTH] = tr_q[j];
    for (int k = 0; k < P_N_NEUR; k++) begin
      o_lv[k*LVW +: LVW]        = lv_q[k];
      o_threshold[k*LVW +: LVW] = thr[k];
    end
  end

  assign o_spike       = spike_q;
  assign o_spike_valid = spike_valid_q;
  assign o_winner      = winner_q;

endmodule

// File: tb/tb_odesa_layer_n.sv
// Scoreboard bench for odesa_layer_n: a behavioural model predicts each event's winner,
// a negedge monitor matches emitted spikes against the expected queue.
module tb_odesa_layer_n;
  localparam int W    = 9;
  localparam int M    = 2;
  localparam int N    = 4;
  localparam int LVW  = 2 * W + $clog2(M);
  localparam int WW   = $clog2(N);
  localparam int ETA  = 4;
  localparam int TDEC = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [M-1:0]         ev;
  logic                 tick;
  logic [N*M*W-1:0]     wt;
  logic [N*LVW-1:0]     thr_in;
  logic [M*W-1:0]       tr_o;
  logic [N*LVW-1:0]     lv_o;
  logic [N*LVW-1:0]     thr_o;
  logic [N-1:0]         spike;
  logic                 spike_valid;
  logic [WW-1:0]        winner;

  odesa_layer_n #(
    .P_WIDTH(W), .P_N_IN(M), .P_N_NEUR(N), .P_DECAY(1), .P_ETA(ETA), .P_THR_DEC(TDEC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_event(ev), .i_tick(tick), .i_weight(wt),
    .i_threshold(thr_in), .o_tr(tr_o), .o_lv(lv_o), .o_threshold(thr_o),
    .o_spike(spike), .o_spike_valid(spike_valid), .o_winner(winner)
  );

  typedef struct {int cyc; int win;} exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  longint mtr[M];
  longint mw[N][M];
  longint cthr[N];
  longint mthr[N];
  int mwin;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Resolve one event exactly as the layer defines it: dot products, thresholds, argmax
  task automatic model_event();
    longint lv[N];
    longint maxv = -1;
    int win = -1;
    for (int k = 0; k < N; k++) begin
      lv[k] = 0;
      for (int j = 0; j < M; j++) lv[k] += mtr[j] * mw[k][j];
      if (lv[k] >= mthr[k] && lv[k] > maxv) maxv = lv[k];
    end
    for (int k = N - 1; k >= 0; k--) if (lv[k] == maxv && lv[k] >= mthr[k]) win = k;
    if (win >= 0) begin
      q.push_back('{cyc: cyc + 3, win: win});
      mwin = win;
`ifdef THRESH_ADAPT_EN
      mthr[win] = mthr[win] + ((lv[win] - mthr[win]) >> ETA);
`endif
    end else begin
`ifdef THRESH_ADAPT_EN
      for (int k = 0; k < N; k++) mthr[k] = (mthr[k] > TDEC) ? mthr[k] - TDEC : 0;
`endif
    end
  endtask

  task automatic drive(input logic [M-1:0] e, input logic t, input bit push);
    ev = e;
    tick = t;
    for (int j = 0; j < M; j++) begin
      if (e[j]) mtr[j] = (1 << W) - 1;
      else if (t) mtr[j] = (mtr[j] > 1) ? mtr[j] - 1 : 0;
    end
    if (e != 0 && push) model_event();
    @(posedge clk);
    #1;
    ev = '0;
    tick = 1'b0;
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < M; j++) wt[(k*M+j)*W +: W] = W'(mw[k][j]);
      thr_in[k*LVW +: LVW] = LVW'(cthr[k]);
    end
  endtask

  task automatic reset_model();
    for (int j = 0; j < M; j++) mtr[j] = 0;
    for (int k = 0; k < N; k++) mthr[k] = cthr[k];
    mwin = 0;
  endtask

  task automatic do_reset();
    apply_cfg();
    rst = 1'b1;
    ev = '0;
    tick = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
  endtask

  task automatic cfg_case1(input longint t);
    for (int k = 0; k < N; k++) begin
      mw[k][0] = 100 * (k + 1);
      mw[k][1] = 0;
      cthr[k] = t;
    end
  endtask

  task automatic check_thr(input string name);
    for (int k = 0; k < N; k++) check(name, thr_o[k*LVW +: LVW], mthr[k]);
  endtask

  // Monitor: every presented spike must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_spike: got none expected winner %0d at cycle %0d",
                 q[0].win, q[0].cyc);
        void'(q.pop_front());
      end
      if (spike_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_spike: got %b expected none (cycle %0d)", spike, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("spike_cycle", cyc, e.cyc);
          check("spike_onehot", spike, longint'(1) << e.win);
          check("winner", winner, e.win);
        end
      end else begin
        check("spike_idle", spike, 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    ev = '0;
    tick = 1'b0;
    wt = '0;
    thr_in = '0;

    // Case 1: single event on input 0, neuron 3 wins
    cfg_case1(150000);
    do_reset();
    check("reset_tr", tr_o, 0);
    check("reset_lv", lv_o, 0);
    check("reset_winner", winner, 0);
    check_thr("reset_thr");
    drive(2'b01, 1'b0, 1'b1);
    check("c1_tr0", tr_o[0 +: W], 511);
    drive(2'b00, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) check("c1_lv", lv_o[k*LVW +: LVW], 51100 * (k + 1));
    drive(2'b00, 1'b0, 1'b0);
    check_thr("c1_thr");
    repeat (2) drive(2'b00, 1'b0, 1'b0);

    // Case 2: equal potentials tie to neuron 0
    for (int k = 0; k < N; k++) begin
      mw[k][0] = 100;
      mw[k][1] = 100;
      cthr[k] = 0;
    end
    do_reset();
    drive(2'b11, 1'b0, 1'b1);
    drive(2'b00, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) check("c2_lv", lv_o[k*LVW +: LVW], 102200);
    repeat (3) drive(2'b00, 1'b0, 1'b0);

    // Case 3: nobody crosses threshold
    cfg_case1(300000);
    do_reset();
    drive(2'b01, 1'b0, 1'b1);
    repeat (2) drive(2'b00, 1'b0, 1'b0);
    check_thr("c3_thr");
    check("c3_winner_held", winner, mwin);
    repeat (2) drive(2'b00, 1'b0, 1'b0);

    // Case 4: decay, then event beating a simultaneous tick
    cfg_case1(150000);
    do_reset();
    drive(2'b01, 1'b0, 1'b1);
    repeat (10) drive(2'b00, 1'b1, 1'b0);
    check("c4_decay", tr_o[0 +: W], 501);
    drive(2'b01, 1'b1, 1'b1);
    check("c4_event_over_tick", tr_o[0 +: W], 511);
    check("c4_tick_tr1", tr_o[W +: W], 0);
    repeat (4) drive(2'b00, 1'b0, 1'b0);

    // Case 5: reset flushes an in-flight event
    drive(2'b01, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    reset_model();
    repeat (3) drive(2'b00, 1'b0, 1'b0);
    check("c5_tr", tr_o, 0);
    check("c5_lv", lv_o, 0);
    check("c5_valid", spike_valid, 0);
    check("c5_winner", winner, 0);
    check_thr("c5_thr");

    // Randomised phases with back-to-back events
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < M; j++) mw[k][j] = $urandom_range(0, 511);
        cthr[k] = $urandom_range(20000, 300000);
      end
      do_reset();
      for (int c = 0; c < 150; c++) begin
        logic [M-1:0] e;
        e = ($urandom_range(0, 2) == 0) ? '0 : M'($urandom_range(0, (1 << M) - 1));
        drive(e, 1'($urandom_range(0, 1)), 1'b1);
        for (int j = 0; j < M; j++) check("rand_tr", tr_o[j*W +: W], mtr[j]);
      end
      repeat (4) drive(2'b00, 1'b0, 1'b0);
      check("rand_winner_held", winner, mwin);
      check_thr("rand_thr");
    end

    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
